regfile_scan_ctrl: RTL
======================

// Module: regfile_scan_ctrl
// PURPOSE
//   Run/scan sequencer for the processor + regfile test harness. On start, enables the CPU
//   for exactly N clock cycles and counts nonzero-register writes. It then freezes the CPU,
//   takes over regfile read port A, and streams every register out over a valid/ready port.
//   Sits between processor, regfile and bench/debug logic; replaces ad-hoc rs1 hijacking.
// PARAMETERS
//   NUM_REGS   32  registers scanned (0..NUM_REGS-1)
//   ADDR_W     5   register address width
//   DATA_W     32  register data width
//   CYCLE_W    16  width of run-length and write counters
// PORTS
//   clock        in   1        single clock; all state changes on posedge
//   reset        in   1        synchronous, active-high
//   start        in   1        pulse; accepted only in IDLE or DONE
//   num_cycles   in   CYCLE_W  run length, sampled when start is accepted
//   cpu_en       out  1        CPU clock-enable/advance; high only in RUN
//   proc_rs1     in   ADDR_W   processor ctrl_readRegA
//   rf_rs1       out  ADDR_W   address driven to regfile read port A
//   rf_dataA     in   DATA_W   regfile data_readRegA (combinational read)
//   rf_we        in   1        regfile ctrl_writeEnable
//   rf_rd        in   ADDR_W   regfile ctrl_writeReg
//   out_valid    out  1        scan beat valid
//   out_ready    in   1        consumer accepts beat
//   out_reg      out  ADDR_W   register index of beat
//   out_data     out  DATA_W   register value of beat
//   busy         out  1        high in RUN, SCAN_ADDR, SCAN_OUT
//   done         out  1        high in DONE
//   wr_count     out  CYCLE_W  rf_we && rf_rd!=0 events seen during RUN (saturating)
// BEHAVIOUR
//   States: IDLE, RUN, SCAN_ADDR, SCAN_OUT, DONE.
//   Reset (any state, mid-run or mid-scan): state=IDLE. cpu_en, out_valid, busy and done=0.
//     out_reg, out_data, wr_count and internal counters=0.
//   IDLE/DONE + start: latch num_cycles into len, clear cyc and wr_count, reg index idx=0.
//     Go to RUN if len!=0, else go directly to SCAN_ADDR (cpu_en never asserts).
//   RUN: cpu_en=1, cyc++ each cycle. At cyc==len-1, next state is SCAN_ADDR.
//     cpu_en is therefore high for exactly len consecutive cycles.
//   wr_count: in RUN, +1 per cycle with rf_we=1 and rf_rd!=0; saturates at all-ones.
//     It is held outside RUN and readable in DONE.
//   Read mux: rf_rs1 = idx in SCAN_ADDR/SCAN_OUT, else proc_rs1 (combinational).
//   SCAN_ADDR: rf_rs1=idx. At posedge, out_data<=rf_dataA, out_reg<=idx, go to SCAN_OUT.
//   SCAN_OUT: out_valid=1. out_data and out_reg stable until out_valid&&out_ready.
//     On handshake: if idx==NUM_REGS-1 go to DONE, else idx++ and go to SCAN_ADDR.
//     Minimum 2 cycles per register; with out_ready tied high the scan takes 2*NUM_REGS cycles.
//   out_valid is never high outside SCAN_OUT. out_ready outside SCAN_OUT is ignored.
//   start while busy: ignored (no relatch, no restart).
//   DONE: done=1 and holds until start or reset. start in DONE restarts a full sequence.
//   Register 0 is scanned like the others; its value is whatever the regfile returns (0).
//   Latency: start accepted at cycle t -> cpu_en high t+1..t+len.
//     First out_valid at t+len+2.
// TESTING
//   reset mid-RUN (len=10, reset at cycle 4) -> next cycle IDLE, cpu_en=0, busy=0, wr_count=0
//   len=5, ready=1, regfile preloaded r[i]=i*3 -> cpu_en high exactly 5 cycles; 32 beats
//     out_reg 0..31, out_data 0,3,...,93; done after 64 scan cycles
//   len=0 -> cpu_en never high; scan begins the cycle after start
//   backpressure: out_ready low 7 cycles on beat r7 -> out_valid held; out_reg/out_data
//     stable; no skip, no duplicate
//   rf_we pulses with rd=0,3,0,9 during RUN -> wr_count=2; pulses outside RUN not counted
//   start pulses during RUN and SCAN ignored; start in DONE -> fresh run with new num_cycles
//   proc_rs1=17 in RUN passes to rf_rs1; rf_rs1 is overridden to idx only in scan states

Source files
------------

// File: rtl/regfile_scan_ctrl.sv
// Run/scan sequencer: runs the CPU for a programmed number of cycles, counts register
// writes, then freezes the CPU and streams every regfile entry out over valid/ready.
module regfile_scan_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int CYCLE_W  = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [CYCLE_W-1:0] i_num_cycles,
  output logic               o_cpu_en,
  input  logic [ADDR_W-1:0]  i_proc_rs1,
  output logic [ADDR_W-1:0]  o_rf_rs1,
  input  logic [DATA_W-1:0]  i_rf_data_a,
  input  logic               i_rf_we,
  input  logic [ADDR_W-1:0]  i_rf_rd,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [ADDR_W-1:0]  o_out_reg,
  output logic [DATA_W-1:0]  o_out_data,
  output logic               o_busy,
  output logic               o_done,
  output logic [CYCLE_W-1:0] o_wr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SCAN_ADDR,
    S_SCAN_OUT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t             r_state;
  logic [CYCLE_W-1:0] r_len;
  logic [CYCLE_W-1:0] r_cyc;
  logic [ADDR_W-1:0]  r_idx;
  logic [CYCLE_W-1:0] r_wr_count;
  logic [ADDR_W-1:0]  r_out_reg;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_cpu_en;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_done;

  logic w_scan;
  logic w_count_write;

  // Read port A belongs to the processor except while the scan owns it.
  assign w_scan        = (r_state == S_SCAN_ADDR) || (r_state == S_SCAN_OUT);
  assign o_rf_rs1      = w_scan ? r_idx : i_proc_rs1;
  assign w_count_write = i_rf_we && (i_rf_rd != '0) && (r_wr_count != '1);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cyc       <= '0;
      r_idx       <= '0;
      r_wr_count  <= '0;
      r_out_reg   <= '0;
      r_out_data  <= '0;
      r_cpu_en    <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: outputs are registered, so each one is updated together with the
      // transition into the state that owns it rather than decoded from r_state.
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_len      <= i_num_cycles;
            r_cyc      <= '0;
            r_wr_count <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            if (i_num_cycles != '0) begin
              r_state  <= S_RUN;
              r_cpu_en <= 1'b1;
            end else begin
              r_state  <= S_SCAN_ADDR;
            end
          end
        end
        S_RUN: begin
          r_cyc <= r_cyc + CYCLE_W'(1);
          if (w_count_write) r_wr_count <= r_wr_count + CYCLE_W'(1);
          if (r_cyc == r_len - CYCLE_W'(1)) begin
            r_state  <= S_SCAN_ADDR;
            r_cpu_en <= 1'b0;
          end
        end
        S_SCAN_ADDR: begin
          r_out_data  <= i_rf_data_a;
          r_out_reg   <= r_idx;
          r_out_valid <= 1'b1;
          r_state     <= S_SCAN_OUT;
        end
        S_SCAN_OUT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + ADDR_W'(1);
              r_state <= S_SCAN_ADDR;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cpu_en    = r_cpu_en;
  assign o_out_valid = r_out_valid;
  assign o_out_reg   = r_out_reg;
  assign o_out_data  = r_out_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_wr_count  = r_wr_count;

endmodule
